reservation_station: RTL and testbench

//   Holds issued ALU-class instructions (ARITH, ARITHI, BR, JAL, JALR, LUI, AUIPC) until their operands are ready.

---
 rtl/reservation_station.sv | 154 +++++++++++++++
 tb/tb_reservation_station.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reservation_station.sv
// ALU-side reservation station: buffers issued instructions, snoops ALU/LSB result
// broadcasts for pending operands and dispatches one ready entry per cycle.
module reservation_station #(
  parameter int unsigned RS_SIZE   = 16,
  parameter int unsigned ROB_POS_W = 4,
  parameter int unsigned DATA_W    = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rdy,
  input  logic                 rollback,

  input  logic                 issue,
  input  logic [ROB_POS_W-1:0] issue_rob_pos,
  input  logic [6:0]           issue_opcode,
  input  logic [2:0]           issue_funct3,
  input  logic                 issue_funct7,
  input  logic [DATA_W-1:0]    issue_rs1_val,
  input  logic [DATA_W-1:0]    issue_rs2_val,
  input  logic                 issue_rs1_dep,
  input  logic                 issue_rs2_dep,
  input  logic [ROB_POS_W-1:0] issue_rs1_rob_id,
  input  logic [ROB_POS_W-1:0] issue_rs2_rob_id,
  input  logic [DATA_W-1:0]    issue_imm,
  input  logic [DATA_W-1:0]    issue_pc,

  input  logic                 alu_result,
  input  logic [ROB_POS_W-1:0] alu_result_rob_pos,
  input  logic [DATA_W-1:0]    alu_result_val,
  input  logic                 lsb_result,
  input  logic [ROB_POS_W-1:0] lsb_result_rob_pos,
  input  logic [DATA_W-1:0]    lsb_result_val,

  output logic                 rs_full,
  output logic                 alu_en,
  output logic [6:0]           alu_opcode,
  output logic [2:0]           alu_funct3,
  output logic                 alu_funct7,
  output logic [DATA_W-1:0]    alu_val1,
  output logic [DATA_W-1:0]    alu_val2,
  output logic [DATA_W-1:0]    alu_imm,
  output logic [DATA_W-1:0]    alu_pc,
  output logic [ROB_POS_W-1:0] alu_rob_pos
);

  localparam int unsigned IdxW = (RS_SIZE > 1) ? $clog2(RS_SIZE) : 1;

  typedef struct packed {
    logic [6:0]           opcode;
    logic [2:0]           funct3;
    logic                 funct7;
    logic [DATA_W-1:0]    val1;
    logic [DATA_W-1:0]    val2;
    logic                 dep1;
    logic                 dep2;
    logic [ROB_POS_W-1:0] q1;
    logic [ROB_POS_W-1:0] q2;
    logic [DATA_W-1:0]    imm;
    logic [DATA_W-1:0]    pc;
    logic [ROB_POS_W-1:0] rob_pos;
  } entry_t;

  entry_t             ent_q [RS_SIZE];
  entry_t             ent_d [RS_SIZE];
  logic [RS_SIZE-1:0] busy_q, busy_d;
  logic [IdxW-1:0]    free_idx, sel_idx;
  logic               sel_found;

  assign rs_full = &busy_q;

  // Returns {dep, val} after snooping both broadcasts; the ALU broadcast wins a tie.
  function automatic logic [DATA_W:0] snoop(input logic                 dep,
                                            input logic [ROB_POS_W-1:0] q,
                                            input logic [DATA_W-1:0]    val);
    if (dep && alu_result && (q == alu_result_rob_pos)) return {1'b0, alu_result_val};
    if (dep && lsb_result && (q == lsb_result_rob_pos)) return {1'b0, lsb_result_val};
    return {dep, val};
  endfunction

  // Descending scans leave the lowest matching index in the result.
  always_comb begin
    free_idx  = '0;
    sel_idx   = '0;
    sel_found = 1'b0;
    for (int i = RS_SIZE - 1; i >= 0; i--) begin
      if (!busy_q[i]) free_idx = IdxW'(i);
      if (busy_q[i] && !ent_q[i].dep1 && !ent_q[i].dep2) begin
        sel_idx   = IdxW'(i);
        sel_found = 1'b1;
      end
    end
  end

  always_comb begin
    ent_d  = ent_q;
    busy_d = busy_q;
    for (int i = 0; i < RS_SIZE; i++) begin
      if (busy_q[i]) begin
        {ent_d[i].dep1, ent_d[i].val1} = snoop(ent_q[i].dep1, ent_q[i].q1, ent_q[i].val1);
        {ent_d[i].dep2, ent_d[i].val2} = snoop(ent_q[i].dep2, ent_q[i].q2, ent_q[i].val2);
      end
    end
    if (sel_found) busy_d[sel_idx] = 1'b0;
    if (issue && !rs_full) begin
      busy_d[free_idx]         = 1'b1;
      ent_d[free_idx].opcode   = issue_opcode;
      ent_d[free_idx].funct3   = issue_funct3;
      ent_d[free_idx].funct7   = issue_funct7;
      ent_d[free_idx].q1       = issue_rs1_rob_id;
      ent_d[free_idx].q2       = issue_rs2_rob_id;
      ent_d[free_idx].imm      = issue_imm;
      ent_d[free_idx].pc       = issue_pc;
      ent_d[free_idx].rob_pos  = issue_rob_pos;
      {ent_d[free_idx].dep1, ent_d[free_idx].val1} =
          snoop(issue_rs1_dep, issue_rs1_rob_id, issue_rs1_val);
      {ent_d[free_idx].dep2, ent_d[free_idx].val2} =
          snoop(issue_rs2_dep, issue_rs2_rob_id, issue_rs2_val);
    end
  end

  always_ff @(posedge clk) begin
    if (rst || rollback) begin
      busy_q      <= '0;
      alu_en      <= 1'b0;
      alu_opcode  <= '0;
      alu_funct3  <= '0;
      alu_funct7  <= 1'b0;
      alu_val1    <= '0;
      alu_val2    <= '0;
      alu_imm     <= '0;
      alu_pc      <= '0;
      alu_rob_pos <= '0;
    end else if (rdy) begin
      busy_q <= busy_d;
      alu_en <= sel_found;
      if (sel_found) begin
        alu_opcode  <= ent_q[sel_idx].opcode;
        alu_funct3  <= ent_q[sel_idx].funct3;
        alu_funct7  <= ent_q[sel_idx].funct7;
        alu_val1    <= ent_q[sel_idx].val1;
        alu_val2    <= ent_q[sel_idx].val2;
        alu_imm     <= ent_q[sel_idx].imm;
        alu_pc      <= ent_q[sel_idx].pc;
        alu_rob_pos <= ent_q[sel_idx].rob_pos;
      end
    end
  end

  // Payload is meaningless while its busy bit is clear, so it carries no reset.
  always_ff @(posedge clk) begin
    if (rdy) ent_q <= ent_d;
  end

endmodule

// File: tb/tb_reservation_station.sv
// Directed scenarios followed by random traffic, all checked cycle by cycle against
// a slot-array reference model of the station.
module tb_reservation_station;

  logic        clk = 1'b0;
  logic        rst, rdy, rollback, issue;
  logic [3:0]  issue_rob_pos, issue_rs1_rob_id, issue_rs2_rob_id;
  logic [6:0]  issue_opcode;
  logic [2:0]  issue_funct3;
  logic        issue_funct7, issue_rs1_dep, issue_rs2_dep;
  logic [31:0] issue_rs1_val, issue_rs2_val, issue_imm, issue_pc;
  logic        alu_result, lsb_result;
  logic [3:0]  alu_result_rob_pos, lsb_result_rob_pos;
  logic [31:0] alu_result_val, lsb_result_val;
  logic        rs_full, alu_en, alu_funct7;
  logic [6:0]  alu_opcode;
  logic [2:0]  alu_funct3;
  logic [31:0] alu_val1, alu_val2, alu_imm, alu_pc;
  logic [3:0]  alu_rob_pos;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  reservation_station dut (
    .clk(clk), .rst(rst), .rdy(rdy), .rollback(rollback),
    .issue(issue), .issue_rob_pos(issue_rob_pos), .issue_opcode(issue_opcode),
    .issue_funct3(issue_funct3), .issue_funct7(issue_funct7),
    .issue_rs1_val(issue_rs1_val), .issue_rs2_val(issue_rs2_val),
    .issue_rs1_dep(issue_rs1_dep), .issue_rs2_dep(issue_rs2_dep),
    .issue_rs1_rob_id(issue_rs1_rob_id), .issue_rs2_rob_id(issue_rs2_rob_id),
    .issue_imm(issue_imm), .issue_pc(issue_pc),
    .alu_result(alu_result), .alu_result_rob_pos(alu_result_rob_pos),
    .alu_result_val(alu_result_val),
    .lsb_result(lsb_result), .lsb_result_rob_pos(lsb_result_rob_pos),
    .lsb_result_val(lsb_result_val),
    .rs_full(rs_full), .alu_en(alu_en), .alu_opcode(alu_opcode), .alu_funct3(alu_funct3),
    .alu_funct7(alu_funct7), .alu_val1(alu_val1), .alu_val2(alu_val2), .alu_imm(alu_imm),
    .alu_pc(alu_pc), .alu_rob_pos(alu_rob_pos)
  );

  // Reference model: a plain array of slots plus the registered dispatch port.
  typedef struct {
    logic [6:0]  op;
    logic [2:0]  f3;
    logic        f7;
    logic [31:0] v1, v2, imm, pc;
    logic        d1, d2;
    logic [3:0]  q1, q2, rob;
  } slot_t;

  slot_t m_slot [16];
  bit    m_busy [16];
  slot_t m_out;
  bit    m_en;

  function automatic logic [32:0] resolve(logic d, logic [3:0] q, logic [31:0] v);
    if (!d) return {1'b0, v};
    if (alu_result && alu_result_rob_pos == q) return {1'b0, alu_result_val};
    if (lsb_result && lsb_result_rob_pos == q) return {1'b0, lsb_result_val};
    return {1'b1, v};
  endfunction

  task automatic model_step();
    slot_t nxt [16];
    bit    nb [16];
    int    pick = -1;
    int    hole = -1;
    int    used = 0;
    if (rst || rollback) begin
      foreach (m_busy[i]) m_busy[i] = 0;
      m_en = 0;
      m_out = '{op: 0, f3: 0, f7: 0, v1: 0, v2: 0, imm: 0, pc: 0, d1: 0, d2: 0,
                q1: 0, q2: 0, rob: 0};
      return;
    end
    if (!rdy) return;
    foreach (m_busy[i]) begin
      if (m_busy[i]) used++;
      if (hole < 0 && !m_busy[i]) hole = i;
      if (pick < 0 && m_busy[i] && !m_slot[i].d1 && !m_slot[i].d2) pick = i;
    end
    nxt = m_slot;
    nb  = m_busy;
    foreach (m_busy[i]) if (m_busy[i]) begin
      {nxt[i].d1, nxt[i].v1} = resolve(m_slot[i].d1, m_slot[i].q1, m_slot[i].v1);
      {nxt[i].d2, nxt[i].v2} = resolve(m_slot[i].d2, m_slot[i].q2, m_slot[i].v2);
    end
    m_en = (pick >= 0);
    if (pick >= 0) begin
      m_out = m_slot[pick];
      nb[pick] = 0;
    end
    if (issue && used < 16) begin
      nb[hole] = 1;
      nxt[hole].op  = issue_opcode;  nxt[hole].f3 = issue_funct3; nxt[hole].f7 = issue_funct7;
      nxt[hole].imm = issue_imm;     nxt[hole].pc = issue_pc;     nxt[hole].rob = issue_rob_pos;
      nxt[hole].q1  = issue_rs1_rob_id;
      nxt[hole].q2  = issue_rs2_rob_id;
      {nxt[hole].d1, nxt[hole].v1} = resolve(issue_rs1_dep, issue_rs1_rob_id, issue_rs1_val);
      {nxt[hole].d2, nxt[hole].v2} = resolve(issue_rs2_dep, issue_rs2_rob_id, issue_rs2_val);
    end
    m_slot = nxt;
    m_busy = nb;
  endtask

  function automatic bit model_full();
    foreach (m_busy[i]) if (!m_busy[i]) return 0;
    return 1;
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_model();
    chk("rs_full", rs_full, model_full());
    chk("alu_en", alu_en, m_en);
    chk("alu_opcode", alu_opcode, m_out.op);
    chk("alu_funct3", alu_funct3, m_out.f3);
    chk("alu_funct7", alu_funct7, m_out.f7);
    chk("alu_val1", alu_val1, m_out.v1);
    chk("alu_val2", alu_val2, m_out.v2);
    chk("alu_imm", alu_imm, m_out.imm);
    chk("alu_pc", alu_pc, m_out.pc);
    chk("alu_rob_pos", alu_rob_pos, m_out.rob);
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
    check_model();
  endtask

  task automatic quiet();
    rst = 0; rollback = 0; issue = 0; alu_result = 0; lsb_result = 0;
    issue_rs1_dep = 0; issue_rs2_dep = 0;
  endtask

  task automatic set_issue(logic [3:0] rob, logic [31:0] v1, logic d1, logic [3:0] q1,
                           logic [31:0] v2, logic d2, logic [3:0] q2);
    issue = 1; issue_rob_pos = rob; issue_opcode = 7'h33; issue_funct3 = 3'd0;
    issue_funct7 = 0; issue_rs1_val = v1; issue_rs1_dep = d1; issue_rs1_rob_id = q1;
    issue_rs2_val = v2; issue_rs2_dep = d2; issue_rs2_rob_id = q2;
    issue_imm = 32'h100 + 32'(rob); issue_pc = 32'h4000 + 32'(rob) * 4;
  endtask

  task automatic bcast_alu(logic [3:0] pos, logic [31:0] val);
    alu_result = 1; alu_result_rob_pos = pos; alu_result_val = val;
  endtask

  initial begin
    rdy = 1; quiet();
    issue_rob_pos = 0; issue_opcode = 0; issue_funct3 = 0; issue_funct7 = 0;
    issue_rs1_val = 0; issue_rs2_val = 0; issue_rs1_rob_id = 0; issue_rs2_rob_id = 0;
    issue_imm = 0; issue_pc = 0;
    alu_result_rob_pos = 0; alu_result_val = 0; lsb_result_rob_pos = 0; lsb_result_val = 0;
    foreach (m_busy[i]) m_busy[i] = 0;
    rst = 1;
    cycle(); cycle();
    chk("reset_alu_en", alu_en, 0);
    chk("reset_rs_full", rs_full, 0);
    quiet();

    // Ready ADD dispatches two edges after issue, then the port goes idle.
    set_issue(4'd3, 32'd5, 0, 4'd0, 32'd7, 0, 4'd0);
    cycle(); quiet();
    chk("t1_not_yet", alu_en, 0);
    cycle();
    chk("t1_en", alu_en, 1);
    chk("t1_rob", alu_rob_pos, 3);
    chk("t1_v1", alu_val1, 5);
    chk("t1_v2", alu_val2, 7);
    cycle();
    chk("t1_idle", alu_en, 0);

    // rs1 waits for rob 2, woken by an ALU broadcast.
    set_issue(4'd4, 32'd0, 1, 4'd2, 32'd1, 0, 4'd0);
    cycle(); quiet();
    cycle(); cycle();
    chk("t2_blocked", alu_en, 0);
    bcast_alu(4'd2, 32'h10);
    cycle(); quiet();
    cycle();
    chk("t2_en", alu_en, 1);
    chk("t2_v1", alu_val1, 32'h10);

    // Same-cycle LSB bypass at issue.
    set_issue(4'd5, 32'd9, 0, 4'd0, 32'd0, 1, 4'd6);
    lsb_result = 1; lsb_result_rob_pos = 4'd6; lsb_result_val = 32'hAB;
    cycle(); quiet();
    cycle();
    chk("t3_en", alu_en, 1);
    chk("t3_v2", alu_val2, 32'hAB);
    cycle();

    // Fill every slot with a blocked entry (slot i waits on rob i).
    for (int i = 0; i < 16; i++) begin
      set_issue(4'(i), 32'd0, 1, 4'(i), 32'(i), 0, 4'd0);
      cycle();
    end
    quiet();
    chk("t4_full", rs_full, 1);
    set_issue(4'd7, 32'hDEAD, 0, 4'd0, 32'hBEEF, 0, 4'd0);
    cycle(); quiet();
    chk("t4_still_full", rs_full, 1);
    bcast_alu(4'd0, 32'h55);
    cycle(); quiet();
    cycle();
    chk("t4_en", alu_en, 1);
    chk("t4_rob", alu_rob_pos, 0);
    chk("t4_drop", rs_full, 0);
    for (int i = 1; i < 16; i++) begin
      bcast_alu(4'(i), 32'(i) * 3);
      cycle();
    end
    quiet();
    repeat (3) cycle();

    // Rollback with three busy slots and a dispatch on the port.
    set_issue(4'd1, 32'd0, 1, 4'd1, 32'd0, 0, 4'd0); cycle();
    set_issue(4'd2, 32'd0, 1, 4'd2, 32'd0, 0, 4'd0); cycle();
    set_issue(4'd10, 32'd1, 0, 4'd0, 32'd2, 0, 4'd0); cycle();
    set_issue(4'd11, 32'd3, 0, 4'd0, 32'd4, 0, 4'd0); cycle();
    quiet();
    chk("t5_pre_en", alu_en, 1);
    rollback = 1;
    cycle(); quiet();
    chk("t5_en", alu_en, 0);
    chk("t5_full", rs_full, 0);
    bcast_alu(4'd1, 32'h1); lsb_result = 1; lsb_result_rob_pos = 4'd2;
    cycle(); quiet();
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("t5_no_dispatch", alu_en, 0);
    end

    // rdy=0 freezes wakeup and the dispatch port.
    set_issue(4'd8, 32'd0, 1, 4'd3, 32'd0, 0, 4'd0); cycle();
    set_issue(4'd9, 32'd6, 0, 4'd0, 32'd6, 0, 4'd0); cycle();
    quiet();
    cycle();
    chk("t6_pre_en", alu_en, 1);
    rdy = 0;
    bcast_alu(4'd3, 32'h77);
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("t6_held", alu_en, 1);
    end
    rdy = 1; quiet();
    cycle();
    chk("t6_no_wake", alu_en, 0);
    bcast_alu(4'd3, 32'h99);
    cycle(); quiet();
    cycle();
    chk("t6_en", alu_en, 1);
    chk("t6_rob", alu_rob_pos, 8);
    chk("t6_v1", alu_val1, 32'h99);

    // Random traffic.
    for (int n = 0; n < 3000; n++) begin
      quiet();
      rdy      = ($urandom_range(0, 9) != 0);
      rollback = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 2) != 0) begin
        issue = 1;
        issue_rob_pos = 4'($urandom); issue_opcode = 7'($urandom);
        issue_funct3 = 3'($urandom); issue_funct7 = 1'($urandom);
        issue_rs1_val = $urandom; issue_rs2_val = $urandom;
        issue_rs1_dep = ($urandom_range(0, 2) == 0);
        issue_rs2_dep = ($urandom_range(0, 2) == 0);
        issue_rs1_rob_id = 4'($urandom); issue_rs2_rob_id = 4'($urandom);
        issue_imm = $urandom; issue_pc = $urandom;
      end
      if ($urandom_range(0, 1) != 0) bcast_alu(4'($urandom), $urandom);
      if ($urandom_range(0, 1) != 0) begin
        lsb_result = 1; lsb_result_rob_pos = 4'($urandom); lsb_result_val = $urandom;
      end
      cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
